// File: rtl/bpsk_frame_transmitter_if.sv
// rtl/bpsk_frame_transmitter_if.sv - payload byte stream into the BPSK frame transmitter
//
// Purpose: groups the valid/ready byte handshake feeding the transmitter.
// Signals:
//   in_data   8  payload byte (producer -> transmitter)
//   in_valid  1  in_data valid (producer -> transmitter)
//   in_ready  1  transmitter accepts in_data this cycle (transmitter -> producer)
// Modports: master = byte producer, slave = transmitter.

interface bpsk_frame_transmitter_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/bpsk_frame_transmitter.sv
// rtl/bpsk_frame_transmitter.sv - preamble framer and binary BPSK modulator
//
// Purpose: accepts payload bytes over a valid/ready stream and emits a framed
// 1-bit sample stream: PREAMBLE_WIDTH preamble symbols, then FRAME_BYTES
// payload bytes MSB-first, each symbol WAVELENGTH samples long.
// Sample = carrier XOR symbol bit, carrier = (phase < WAVELENGTH/2).
//
// Optional feature: define BPSK_TX_PARITY_EN to append one even-parity
// symbol (XOR of all payload bits) after the last payload byte.
//
// Ports:
//   clk       in   clock
//   reset_n   in   asynchronous active-low reset
//   in_s      slave modport of bpsk_frame_transmitter_if (in_data/in_valid/in_ready)
//   signal    out  BPSK sample stream (0 while idle)
//   phase     out  sample index within the current symbol
//   busy      out  frame in progress
//   underrun  out  one-cycle pulse: frame aborted, next byte was not available

module bpsk_frame_transmitter #(
  parameter int                        WAVELENGTH     = 8,
  parameter int                        PREAMBLE_WIDTH = 8,
  parameter logic [PREAMBLE_WIDTH-1:0] PREAMBLE       = 8'b1011_0010,
  parameter int                        FRAME_BYTES    = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  bpsk_frame_transmitter_if.slave       in_s,
  output logic                          signal,
  output logic [$clog2(WAVELENGTH):0]   phase,
  output logic                          busy,
  output logic                          underrun
);

  localparam int PHW = $clog2(WAVELENGTH) + 1;
  localparam int SIW = $clog2(PREAMBLE_WIDTH) + 1;
  localparam int BCW = $clog2(FRAME_BYTES) + 1;

  localparam logic [PHW-1:0] PH_LAST = PHW'(WAVELENGTH - 1);
  localparam logic [PHW-1:0] PH_HALF = PHW'(WAVELENGTH / 2);
  localparam logic [SIW-1:0] SI_LAST = SIW'(PREAMBLE_WIDTH - 1);
  localparam logic [BCW-1:0] BC_LAST = BCW'(FRAME_BYTES - 1);

`ifdef BPSK_TX_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_PAYLOAD, S_PARITY} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_PAYLOAD} state_t;
`endif

  state_t                    state, state_n;
  logic [PHW-1:0]            ph, ph_n;
  logic [SIW-1:0]            sym_idx, sym_idx_n;
  logic [PREAMBLE_WIDTH-1:0] pre_sr, pre_sr_n;
  logic [2:0]                bit_cnt, bit_cnt_n;
  logic [BCW-1:0]            byte_cnt, byte_cnt_n;
  logic [7:0]                shift, shift_n;
  logic [7:0]                hold, hold_n;
  logic                      hold_full, hold_full_n;
  logic                      underrun_q, underrun_n;
`ifdef BPSK_TX_PARITY_EN
  logic                      par, par_n;
`endif

  logic sym_end;
  logic xfer;
  logic sym_bit;

  assign sym_end     = (ph == PH_LAST);
  assign in_s.in_ready = ~hold_full;
  assign xfer        = in_s.in_valid & ~hold_full;

  // Outputs decode from registered state only; no input reaches signal.
  always_comb begin
    sym_bit = 1'b0;
    case (state)
      S_PREAMBLE: sym_bit = pre_sr[PREAMBLE_WIDTH-1];
      S_PAYLOAD:  sym_bit = shift[7];
`ifdef BPSK_TX_PARITY_EN
      S_PARITY:   sym_bit = par;
`endif
      default:    sym_bit = 1'b0;
    endcase
  end

  assign busy     = (state != S_IDLE);
  assign signal   = busy & ((ph < PH_HALF) ^ sym_bit);
  assign phase    = ph;
  assign underrun = underrun_q;

  // Next-state and datapath.
  always_comb begin
    state_n     = state;
    ph_n        = (state == S_IDLE) ? '0 : (sym_end ? '0 : ph + PHW'(1));
    sym_idx_n   = sym_idx;
    pre_sr_n    = pre_sr;
    bit_cnt_n   = bit_cnt;
    byte_cnt_n  = byte_cnt;
    shift_n     = shift;
    hold_n      = hold;
    hold_full_n = hold_full;
    underrun_n  = 1'b0;
`ifdef BPSK_TX_PARITY_EN
    par_n       = par;
`endif

    // Transfers only happen while hold is empty, so they never collide with
    // a consume of a full hold; the bypass case below overrides hold_full_n.
    if (xfer) begin
      hold_n      = in_s.in_data;
      hold_full_n = 1'b1;
    end

    case (state)
      S_IDLE: begin
        // A leftover byte in hold starts the next frame after one idle cycle.
        if (hold_full || xfer) begin
          state_n    = S_PREAMBLE;
          ph_n       = '0;
          sym_idx_n  = '0;
          pre_sr_n   = PREAMBLE;
          bit_cnt_n  = '0;
          byte_cnt_n = '0;
`ifdef BPSK_TX_PARITY_EN
          par_n      = 1'b0;
`endif
        end
      end

      S_PREAMBLE: begin
        if (sym_end) begin
          pre_sr_n = pre_sr << 1;
          if (sym_idx == SI_LAST) begin
            // hold is always full here: the frame only starts with a byte.
            state_n     = S_PAYLOAD;
            shift_n     = hold;
            hold_full_n = 1'b0;
            bit_cnt_n   = '0;
            byte_cnt_n  = '0;
          end else begin
            sym_idx_n = sym_idx + SIW'(1);
          end
        end
      end

      S_PAYLOAD: begin
        if (sym_end) begin
`ifdef BPSK_TX_PARITY_EN
          par_n = par ^ shift[7];
`endif
          shift_n   = shift << 1;
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (byte_cnt == BC_LAST) begin
`ifdef BPSK_TX_PARITY_EN
              state_n = S_PARITY;
`else
              state_n = S_IDLE;
`endif
            end else if (hold_full) begin
              shift_n     = hold;
              hold_full_n = 1'b0;
              byte_cnt_n  = byte_cnt + BCW'(1);
            end else if (xfer) begin
              // Byte arriving exactly at the byte boundary goes straight in.
              shift_n     = in_s.in_data;
              hold_full_n = 1'b0;
              byte_cnt_n  = byte_cnt + BCW'(1);
            end else begin
              underrun_n = 1'b1;
              state_n    = S_IDLE;
            end
          end
        end
      end

`ifdef BPSK_TX_PARITY_EN
      S_PARITY: begin
        if (sym_end) state_n = S_IDLE;
      end
`endif

      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      ph         <= '0;
      sym_idx    <= '0;
      pre_sr     <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      shift      <= '0;
      hold       <= '0;
      hold_full  <= 1'b0;
      underrun_q <= 1'b0;
`ifdef BPSK_TX_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      ph         <= ph_n;
      sym_idx    <= sym_idx_n;
      pre_sr     <= pre_sr_n;
      bit_cnt    <= bit_cnt_n;
      byte_cnt   <= byte_cnt_n;
      shift      <= shift_n;
      hold       <= hold_n;
      hold_full  <= hold_full_n;
      underrun_q <= underrun_n;
`ifdef BPSK_TX_PARITY_EN
      par        <= par_n;
`endif
    end
  end

endmodule

// File: tb/tb_bpsk_frame_transmitter.sv
// tb/tb_bpsk_frame_transmitter.sv - directed self-checking bench for bpsk_frame_transmitter

module tb_bpsk_frame_transmitter;

  localparam int W  = 8;
  localparam int PW = 8;
  localparam int FB = 2;
`ifdef BPSK_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FLEN = (PW + 8 * FB + PAR) * W;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       signal;
  logic [3:0] phase;
  logic       busy;
  logic       underrun;

  bpsk_frame_transmitter_if bus();

  bpsk_frame_transmitter dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_s     (bus),
    .signal   (signal),
    .phase    (phase),
    .busy     (busy),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  int vec  = 0;
  int errs = 0;

  logic [7:0] tx_q[$];
  bit         s_sig[$];
  bit         s_busy[$];
  bit         s_und[$];
  int         s_ph[$];

  task automatic clear_log();
    s_sig.delete(); s_busy.delete(); s_und.delete(); s_ph.delete();
  endtask

  // Sample outputs on each falling edge, then offer the next queued byte
  // when the DUT shows ready (the transfer lands on the next rising edge).
  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      s_sig.push_back(signal);
      s_busy.push_back(busy);
      s_und.push_back(underrun);
      s_ph.push_back(int'(phase));
      if (bus.in_ready && tx_q.size() > 0) begin
        bus.in_data  = tx_q.pop_front();
        bus.in_valid = 1'b1;
      end else begin
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
      end
    end
  endtask

  function automatic int first_busy();
    for (int i = 0; i < s_busy.size(); i++) if (s_busy[i]) return i;
    return -1;
  endfunction

  function automatic int run_len(input int s);
    int n = 0;
    while (s + n < s_busy.size() && s_busy[s + n]) n++;
    return n;
  endfunction

  function automatic int und_count();
    int n = 0;
    foreach (s_und[i]) if (s_und[i]) n++;
    return n;
  endfunction

  // Symbol bit from the phase-0 sample: carrier is 1 there, so bit = ~sample.
  function automatic logic [23:0] decode24(input int s);
    logic [23:0] r = '0;
    for (int j = 0; j < 24; j++) r = {r[22:0], ~s_sig[s + j * W]};
    return r;
  endfunction

  function automatic logic [15:0] wave16(input int s);
    logic [15:0] r = '0;
    for (int i = 0; i < 16; i++) r = {r[14:0], s_sig[s + i]};
    return r;
  endfunction

  function automatic logic [31:0] phase8(input int s);
    logic [31:0] r = '0;
    for (int i = 0; i < 8; i++) r = {r[27:0], 4'(s_ph[s + i])};
    return r;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(negedge clk);
    vec++; if (signal !== 1'b0)   begin errs++; $display("FAIL reset_signal: got %0h expected 0", signal); end
    vec++; if (busy !== 1'b0)     begin errs++; $display("FAIL reset_busy: got %0h expected 0", busy); end
    vec++; if (phase !== 4'd0)    begin errs++; $display("FAIL reset_phase: got %0h expected 0", phase); end
    vec++; if (underrun !== 1'b0) begin errs++; $display("FAIL reset_underrun: got %0h expected 0", underrun); end
    vec++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready: got %0h expected 1", bus.in_ready); end
    reset_n = 1'b1;

    // Start a frame, then reset it asynchronously mid-stream.
    clear_log();
    tx_q = '{8'hC3};
    run_cycles(40);
    vec++; if (s_busy[39] !== 1'b1) begin errs++; $display("FAIL reset_pre_busy: got %0h expected 1", s_busy[39]); end
    #2 reset_n = 1'b0;
    #1;
    vec++; if (busy !== 1'b0 || signal !== 1'b0 || phase !== 4'd0 || bus.in_ready !== 1'b1)
      begin errs++; $display("FAIL reset_async: got busy=%0h signal=%0h phase=%0h in_ready=%0h expected 0 0 0 1", busy, signal, phase, bus.in_ready); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset_n = 1'b1;
    clear_log();
    run_cycles(30);
    begin
      int bad = 0;
      for (int i = 0; i < 30; i++) if (s_busy[i] || s_sig[i] || s_und[i] || s_ph[i] != 0) bad++;
      vec++; if (bad != 0) begin errs++; $display("FAIL reset_idle_quiet: got %0d active samples expected 0", bad); end
    end
    vec++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL reset_idle_ready: got %0h expected 1", bus.in_ready); end
  endtask

  task automatic check_frame_a5_3c(input string tag);
    int b;
    b = first_busy();
    vec++; if (b != 1) begin errs++; $display("FAIL %s_start: got %0d expected 1", tag, b); end
    if (b < 0 || b + FLEN + 1 > s_sig.size()) begin
      vec++; errs++; $display("FAIL %s_window: frame start %0d does not fit log of %0d", tag, b, s_sig.size());
    end else begin
      vec++; if (run_len(b) != FLEN) begin errs++; $display("FAIL %s_busy_len: got %0d expected %0d", tag, run_len(b), FLEN); end
      vec++; if (wave16(b) !== 16'h0FF0) begin errs++; $display("FAIL %s_wave16: got %04h expected 0ff0", tag, wave16(b)); end
      vec++; if (phase8(b) !== 32'h01234567) begin errs++; $display("FAIL %s_phase: got %08h expected 01234567", tag, phase8(b)); end
      vec++; if (decode24(b) !== 24'hB2A53C) begin errs++; $display("FAIL %s_symbols: got %06h expected b2a53c", tag, decode24(b)); end
`ifdef BPSK_TX_PARITY_EN
      vec++; if (s_sig[b + 24 * W] !== 1'b1) begin errs++; $display("FAIL %s_parity0: got sample %0h expected 1", tag, s_sig[b + 24 * W]); end
`endif
    end
    vec++; if (und_count() != 0) begin errs++; $display("FAIL %s_no_underrun: got %0d pulses expected 0", tag, und_count()); end
  endtask

  task automatic test_single_frame();
    clear_log();
    tx_q = '{8'hA5, 8'h3C};
    run_cycles(FLEN + 20);
    check_frame_a5_3c("single");
  endtask

`ifdef BPSK_TX_PARITY_EN
  task automatic test_parity();
    int b;
    logic [7:0] w;
    clear_log();
    tx_q = '{8'h01, 8'h00};
    run_cycles(FLEN + 20);
    b = first_busy();
    if (b < 0 || b + FLEN + 1 > s_sig.size()) begin
      vec++; errs++; $display("FAIL parity_window: frame start %0d", b);
    end else begin
      vec++; if (run_len(b) != 200) begin errs++; $display("FAIL parity_len: got %0d expected 200", run_len(b)); end
      w = '0;
      for (int i = 0; i < 8; i++) w = {w[6:0], s_sig[b + 192 + i]};
      vec++; if (w !== 8'h0F) begin errs++; $display("FAIL parity_symbol: got %02h expected 0f", w); end
    end
  endtask
`endif

  task automatic test_underrun();
    int b;
    int u;
    clear_log();
    tx_q = '{8'h55};
    run_cycles(160);
    b = first_busy();
    u = -1;
    foreach (s_und[i]) if (s_und[i] && u < 0) u = i;
    vec++; if (und_count() != 1) begin errs++; $display("FAIL underrun_count: got %0d expected 1", und_count()); end
    vec++; if (b < 0 || u != b + 128) begin errs++; $display("FAIL underrun_cycle: got %0d expected %0d", u, b + 128); end
    if (b >= 0) begin
      vec++; if (run_len(b) != 128) begin errs++; $display("FAIL underrun_busy_len: got %0d expected 128", run_len(b)); end
    end
    if (u >= 0) begin
      vec++; if (s_busy[u] !== 1'b0) begin errs++; $display("FAIL underrun_busy_low: got %0h expected 0", s_busy[u]); end
    end
  endtask

  task automatic test_back_to_back();
    int starts[$];
    int lens[$];
    logic [23:0] exp;
    clear_log();
    tx_q.delete();
    for (int i = 0; i < 6; i++) tx_q.push_back(8'(8'h10 + i));
    run_cycles(3 * (FLEN + 1) + 20);
    for (int i = 0; i < s_busy.size(); i++)
      if (s_busy[i] && (i == 0 || !s_busy[i - 1])) begin
        starts.push_back(i);
        lens.push_back(run_len(i));
      end
    vec++; if (starts.size() != 3) begin errs++; $display("FAIL b2b_frames: got %0d expected 3", starts.size()); end
    for (int f = 0; f < 3 && f < starts.size(); f++) begin
      vec++; if (lens[f] != FLEN) begin errs++; $display("FAIL b2b_len%0d: got %0d expected %0d", f, lens[f], FLEN); end
      if (f > 0) begin
        vec++; if (starts[f] - (starts[f-1] + lens[f-1]) != 1)
          begin errs++; $display("FAIL b2b_gap%0d: got %0d expected 1", f, starts[f] - (starts[f-1] + lens[f-1])); end
      end
      exp = {8'hB2, 8'(8'h10 + 2 * f), 8'(8'h11 + 2 * f)};
      if (starts[f] + 24 * W <= s_sig.size()) begin
        vec++; if (decode24(starts[f]) !== exp) begin errs++; $display("FAIL b2b_data%0d: got %06h expected %06h", f, decode24(starts[f]), exp); end
      end else begin
        vec++; errs++; $display("FAIL b2b_data%0d: frame truncated", f);
      end
    end
    vec++; if (und_count() != 0) begin errs++; $display("FAIL b2b_no_underrun: got %0d expected 0", und_count()); end
  endtask

  task automatic test_reset_mid_payload();
    clear_log();
    tx_q = '{8'hF0, 8'h0F};
    run_cycles(100);
    vec++; if (s_busy[99] !== 1'b1) begin errs++; $display("FAIL midrst_pre_busy: got %0h expected 1", s_busy[99]); end
    #2 reset_n = 1'b0;
    #1;
    vec++; if (busy !== 1'b0 || signal !== 1'b0 || phase !== 4'd0 || underrun !== 1'b0 || bus.in_ready !== 1'b1)
      begin errs++; $display("FAIL midrst_async: got busy=%0h signal=%0h phase=%0h underrun=%0h in_ready=%0h expected 0 0 0 0 1", busy, signal, phase, underrun, bus.in_ready); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset_n = 1'b1;
    clear_log();
    tx_q = '{8'hA5, 8'h3C};
    run_cycles(FLEN + 20);
    check_frame_a5_3c("midrst");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_frame();
`ifdef BPSK_TX_PARITY_EN
    test_parity();
`endif
    test_underrun();
    test_back_to_back();
    test_reset_mid_payload();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/bpsk_frame_transmitter.md
# bpsk_frame_transmitter

Transmit-side framer and binary BPSK modulator. Accepts payload bytes over a valid/ready stream and emits a framed 1-bit sample stream: the preamble symbols, then payload symbols MSB-first. It feeds the channel that the receiver's binary cross-correlator searches, so its preamble waveform must match that correlator's reference bit-for-bit.

## Interface
- WAVELENGTH, default 8: samples per symbol (carrier period); even, ≥2.
- PREAMBLE_WIDTH, default 8: preamble length in symbols.
- PREAMBLE, default 8'b1011_0010: preamble bits, sent MSB first.
- FRAME_BYTES, default 2: payload bytes per frame, ≥1.
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- in_data  in  8  payload byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts in_data this cycle.
- signal  out  1  BPSK sample stream.
- phase  out  $clog2(WAVELENGTH)+1  sample index within the current symbol.
- busy  out  1  frame in progress.
- underrun  out  1  one-cycle pulse: frame aborted because no byte was available.

## Operation
- States: IDLE, PREAMBLE, PAYLOAD, PARITY (only with the macro).
- Carrier: carrier = (phase < WAVELENGTH/2). Output signal = carrier XOR symbol bit while busy; signal = 0 in IDLE.
- signal, busy and phase decode from registered state only; there is no combinational path from inputs to signal.
- One-byte holding register (hold, hold_full) plus an 8-bit shift register.
- in_ready = !hold_full in every state. A transfer occurs on in_valid && in_ready.
- IDLE: a transfer loads hold and moves to PREAMBLE with phase=0, symbol index 0.
- Phase counts 0..WAVELENGTH-1 and wraps. The symbol advances when phase wraps.
- PREAMBLE: symbol i is PREAMBLE[PREAMBLE_WIDTH-1-i]. After the last preamble symbol:
  - move hold to the shift register and clear hold_full;
  - enter PAYLOAD with byte count 0.
- PAYLOAD: the current symbol is shift[7]; the register shifts left at each symbol end. At the end of the 8th symbol of a byte:
  - if byte count == FRAME_BYTES-1: go to PARITY if enabled, else IDLE;
  - else if hold_full (including a transfer in that same cycle): load shift from hold and increment byte count;
  - else: pulse underrun, go to IDLE, discard the partial frame.
- A transfer in the same cycle that hold empties is legal; the byte lands in hold.
- Bytes accepted beyond FRAME_BYTES stay in hold and start the next frame. The next frame starts the cycle after return to IDLE.
- IDLE lasts at least one cycle between frames.
- Reset (any time, including mid-frame): state IDLE, hold_full=0, byte count 0, shift 0, phase 0.
- Reset values of outputs: signal=0, busy=0, phase=0, underrun=0, in_ready=1.

## Timing
- Transfer at edge N: busy=1 and phase=0 from cycle N+1. The first preamble sample appears in cycle N+1.
- Frame length in cycles: (PREAMBLE_WIDTH + 8·FRAME_BYTES [+1 with parity]) · WAVELENGTH.
- busy drops in the cycle after the last sample of the frame.
- underrun is high for exactly the first IDLE cycle after an abort.
- A byte needed for symbol k must be transferred no later than the cycle of the last sample of symbol k-1.

## Configuration
- BPSK_TX_PARITY_EN defined: a PARITY state appends one symbol equal to the XOR of all payload bits (even parity) after the last payload byte. The frame is one symbol longer.
- BPSK_TX_PARITY_EN undefined: no PARITY state; IDLE follows the last payload symbol.

## Test plan
- Reset then idle (defaults): reset_n low mid-stream, then high → signal=0, busy=0, phase=0, in_ready=1, underrun never pulses.
- Single frame, bytes 0xA5 and 0x3C presented back-to-back, no parity:
  - busy high exactly 192 cycles;
  - first 8 samples 0,0,0,0,1,1,1,1 (preamble bit 1), next 8 samples 1,1,1,1,0,0,0,0;
  - decoded symbols are 10110010 10100101 00111100.
- Parity build, bytes 0x01 and 0x00 → frame 200 cycles; last symbol samples 0,0,0,0,1,1,1,1 (parity 1).
- Underrun: first byte only, in_valid held low → underrun pulses once at cycle 8·(8+8)+1 after the transfer; busy=0 from the same cycle.
- Back-to-back frames, in_valid held high with an incrementing byte stream → one IDLE cycle between frames; no byte lost or duplicated (check the decoded stream).
- Reset mid-PAYLOAD → outputs return to reset values asynchronously; the next transfer starts a clean frame from preamble symbol 0.
